inst_mem_loader: RTL and testbench

Boot-time writer for the instruction memory write port, which the pipelined core never drives. It accepts a byte stream from the serial receiver, assembles little-endian 32-bit words, writes them to consecutive InstMem addresses from 0, and verifies an XOR checksum. It holds the core in reset until a load completes cleanly, then releases it. It sits between the UART receiver and InstMem's WE_i/AddrW_i/DataW_i, beside the core top.

---
 rtl/inst_mem_loader.sv | 178 +++++++++++++++++
 tb/tb_inst_mem_loader.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: boot-time writer for the InstMem write port.
//
// Takes a byte stream from the serial receiver and writes it into InstMem. The stream is
// a 16-bit word count (low byte first), count*4 little-endian data bytes, and then one
// XOR checksum byte computed over the data bytes only. Words are written to consecutive
// InstMem addresses starting at 0. The core is held in reset until a load finishes with
// a matching checksum.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset; also the only way to start a new load
//   byte_i       stream byte
//   byte_valid_i byte_i valid this cycle
//   byte_ready_o loader accepts a byte this cycle
//   WE_o         InstMem write enable, one-cycle pulse per word
//   AddrW_o      InstMem word address
//   DataW_o      InstMem write data
//   core_rst_o   core reset, held high until a successful load
//   done_o       load complete and checksum matched (sticky)
//   error_o      load failed (sticky until rst_i)
module inst_mem_loader #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              WE_o,
    output logic [ADDR_W-1:0] AddrW_o,
    output logic [31:0]       DataW_o,
    output logic              core_rst_o,
    output logic              done_o,
    output logic              error_o
);

    typedef enum logic [2:0] {
        StCntLo,
        StCntHi,
        StData,
        StCsum,
        StDone,
        StError
    } loaderStateE;

    loaderStateE       state, stateNext;
    logic [7:0]        cntLo, cntLoNext;
    logic [15:0]       wordTotal, wordTotalNext;
    logic [1:0]        byteIdx, byteIdxNext;
    logic [ADDR_W-1:0] wordCnt, wordCntNext;
    logic [23:0]       wordBuf, wordBufNext;   // lanes 0..2; lane 3 goes straight to the output
    logic [7:0]        csum, csumNext;
    logic              weReg, weNext;
    logic [ADDR_W-1:0] addrReg, addrNext;
    logic [31:0]       dataReg, dataNext;

    logic              accept;
    logic [15:0]       fullCount;
    logic              lastWord;

    // Ready drops combinationally with rst_i so no byte is taken while reset is held.
    assign byte_ready_o = !rst_i &&
                          (state == StCntLo || state == StCntHi ||
                           state == StData  || state == StCsum);
    assign accept       = byte_valid_i & byte_ready_o;
    assign fullCount    = {byte_i, cntLo};

    // Compared at 32 bits so a count of MAX_WORDS never needs an address-width wrap.
    assign lastWord = (({{(32 - ADDR_W){1'b0}}, wordCnt} + 32'd1) == {16'd0, wordTotal});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= StCntLo;
            cntLo     <= 8'd0;
            wordTotal <= 16'd0;
            byteIdx   <= 2'd0;
            wordCnt   <= '0;
            wordBuf   <= 24'd0;
            csum      <= 8'd0;
            weReg     <= 1'b0;
            addrReg   <= '0;
            dataReg   <= 32'd0;
        end else begin
            state     <= stateNext;
            cntLo     <= cntLoNext;
            wordTotal <= wordTotalNext;
            byteIdx   <= byteIdxNext;
            wordCnt   <= wordCntNext;
            wordBuf   <= wordBufNext;
            csum      <= csumNext;
            weReg     <= weNext;
            addrReg   <= addrNext;
            dataReg   <= dataNext;
        end
    end

    always_comb begin
        stateNext     = state;
        cntLoNext     = cntLo;
        wordTotalNext = wordTotal;
        byteIdxNext   = byteIdx;
        wordCntNext   = wordCnt;
        wordBufNext   = wordBuf;
        csumNext      = csum;
        weNext        = 1'b0;
        addrNext      = addrReg;
        dataNext      = dataReg;

        case (state)
            StCntLo: begin
                if (accept) begin
                    cntLoNext = byte_i;
                    stateNext = StCntHi;
                end
            end

            StCntHi: begin
                if (accept) begin
                    wordTotalNext = fullCount;
                    byteIdxNext   = 2'd0;
                    wordCntNext   = '0;
                    csumNext      = 8'd0;
                    if ({16'd0, fullCount} > MAX_WORDS) begin
                        stateNext = StError;
                    end else if (fullCount == 16'd0) begin
                        // Empty image: the checksum byte must be zero.
                        stateNext = StCsum;
                    end else begin
                        stateNext = StData;
                    end
                end
            end

            StData: begin
                if (accept) begin
                    csumNext    = csum ^ byte_i;
                    byteIdxNext = byteIdx + 2'd1;
                    if (byteIdx != 2'd3) begin
                        wordBufNext[{byteIdx, 3'b000} +: 8] = byte_i;
                    end else begin
                        weNext   = 1'b1;
                        addrNext = wordCnt;
                        dataNext = {byte_i, wordBuf};
                        if (lastWord) begin
                            stateNext = StCsum;
                        end else begin
                            wordCntNext = wordCnt + {{(ADDR_W - 1){1'b0}}, 1'b1};
                        end
                    end
                end
            end

            StCsum: begin
                if (accept) begin
                    stateNext = (byte_i == csum) ? StDone : StError;
                end
            end

            StDone, StError: begin
                // Terminal until rst_i.
            end

            default: begin
                stateNext = StError;
            end
        endcase
    end

    assign WE_o       = weReg;
    assign AddrW_o    = addrReg;
    assign DataW_o    = dataReg;
    assign done_o     = (state == StDone);
    assign error_o    = (state == StError);
    // Released in the same cycle done_o rises; the last write has already been issued.
    assign core_rst_o = (state != StDone);

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

    localparam int unsigned AW = 12;
    localparam int unsigned MW = 4096;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } writeT;

    logic          clk;
    logic          rst_i;
    logic [7:0]    byte_i;
    logic          byte_valid_i;
    logic          byte_ready_o;
    logic          WE_o;
    logic [AW-1:0] AddrW_o;
    logic [31:0]   DataW_o;
    logic          core_rst_o;
    logic          done_o;
    logic          error_o;

    int checks;
    int errors;
    int weCount;

    writeT         expQ[$];
    logic [31:0]   wordsQ[$];
    writeT         monExp;
    logic [AW-1:0] lastAddr;
    logic [31:0]   lastData;

    inst_mem_loader #(
        .ADDR_W   (AW),
        .MAX_WORDS(MW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .byte_i      (byte_i),
        .byte_valid_i(byte_valid_i),
        .byte_ready_o(byte_ready_o),
        .WE_o        (WE_o),
        .AddrW_o     (AddrW_o),
        .DataW_o     (DataW_o),
        .core_rst_o  (core_rst_o),
        .done_o      (done_o),
        .error_o     (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every WE_o pulse must match the next expected write in order.
    always @(negedge clk) begin
        if (WE_o === 1'b1) begin
            weCount++;
            checks++;
            lastAddr = AddrW_o;
            lastData = DataW_o;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got addr %0h data %08h, required no write",
                         AddrW_o, DataW_o);
            end else begin
                monExp = expQ.pop_front();
                if (AddrW_o !== monExp.addr || DataW_o !== monExp.data) begin
                    errors++;
                    $display("FAIL write_value: got addr %0h data %08h, required addr %0h data %08h",
                             AddrW_o, DataW_o, monExp.addr, monExp.data);
                end
            end
        end
    end

    function automatic logic [7:0] xorOfWords(input int n);
        logic [7:0] x;
        x = 8'd0;
        for (int w = 0; w < n; w++) begin
            x = x ^ wordsQ[w][7:0] ^ wordsQ[w][15:8] ^ wordsQ[w][23:16] ^ wordsQ[w][31:24];
        end
        return x;
    endfunction

    task automatic applyReset();
        @(negedge clk);
        rst_i        = 1'b1;
        byte_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        expQ.delete();
        weCount = 0;
    endtask

    // Drive one byte for one cycle; after the accepting edge WE_o must be high exactly
    // when that byte completed a word.
    task automatic sendByte(input logic [7:0] b, input bit lane3);
        @(negedge clk);
        checks++;
        if (byte_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL byte_ready: got %b, required 1", byte_ready_o);
        end
        byte_i       = b;
        byte_valid_i = 1'b1;
        @(posedge clk);
        #1;
        byte_valid_i = 1'b0;
        checks++;
        if (WE_o !== lane3) begin
            errors++;
            $display("FAIL we_timing: got %b, required %b", WE_o, lane3);
        end
    endtask

    task automatic sendLoad(input int n, input logic [7:0] csumByte, input int gap);
        logic [15:0] cnt;
        writeT       e;
        cnt = 16'(n);
        sendByte(cnt[7:0], 1'b0);
        repeat (gap) @(posedge clk);
        sendByte(cnt[15:8], 1'b0);
        repeat (gap) @(posedge clk);
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                if (k == 3) begin
                    e.addr = AW'(w);
                    e.data = wordsQ[w];
                    expQ.push_back(e);
                end
                sendByte(wordsQ[w][8*k +: 8], k == 3);
                repeat (gap) @(posedge clk);
            end
        end
        sendByte(csumByte, 1'b0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        checks++;
        if ({WE_o, AddrW_o, DataW_o} !== '0) begin
            errors++;
            $display("FAIL reset_write_port: got we %b addr %0h data %08h, required all 0",
                     WE_o, AddrW_o, DataW_o);
        end
        checks++;
        if ({core_rst_o, done_o, error_o, byte_ready_o} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_status: got rst/done/err/rdy %b, required 1000",
                     {core_rst_o, done_o, error_o, byte_ready_o});
        end
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        checks++;
        if (byte_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b, required 1", byte_ready_o);
        end
        expQ.delete();
        weCount = 0;
    endtask

    task automatic test_two_word(input int gap);
        applyReset();
        wordsQ = '{32'h0000_0013, 32'h0010_0093};
        sendLoad(2, xorOfWords(2), gap);
        checks++;
        if ({done_o, core_rst_o, error_o, byte_ready_o} !== 4'b1000) begin
            errors++;
            $display("FAIL two_word_status gap %0d: got done/rst/err/rdy %b, required 1000",
                     gap, {done_o, core_rst_o, error_o, byte_ready_o});
        end
        @(negedge clk);
        checks++;
        if (weCount !== 2 || expQ.size() != 0) begin
            errors++;
            $display("FAIL two_word_writes gap %0d: got %0d writes, %0d pending, required 2, 0",
                     gap, weCount, expQ.size());
        end
    endtask

    task automatic test_bad_csum();
        applyReset();
        wordsQ = '{32'h0000_0013, 32'h0010_0093};
        sendLoad(2, 8'h83, 0);
        checks++;
        if ({done_o, core_rst_o, error_o, byte_ready_o} !== 4'b0110) begin
            errors++;
            $display("FAIL bad_csum_status: got done/rst/err/rdy %b, required 0110",
                     {done_o, core_rst_o, error_o, byte_ready_o});
        end
        @(negedge clk);
        checks++;
        if (weCount !== 2) begin
            errors++;
            $display("FAIL bad_csum_writes: got %0d, required 2", weCount);
        end
    endtask

    task automatic test_zero_count();
        applyReset();
        wordsQ.delete();
        sendLoad(0, 8'h00, 0);
        checks++;
        if ({done_o, core_rst_o, error_o} !== 3'b100 || weCount !== 0) begin
            errors++;
            $display("FAIL zero_good: got done/rst/err %b writes %0d, required 100 writes 0",
                     {done_o, core_rst_o, error_o}, weCount);
        end
        applyReset();
        sendLoad(0, 8'h01, 0);
        checks++;
        if ({done_o, core_rst_o, error_o} !== 3'b011) begin
            errors++;
            $display("FAIL zero_bad: got done/rst/err %b, required 011",
                     {done_o, core_rst_o, error_o});
        end
    endtask

    task automatic test_oversize();
        applyReset();
        sendByte(8'h01, 1'b0);
        sendByte(8'h10, 1'b0);
        checks++;
        if ({error_o, done_o, core_rst_o, byte_ready_o} !== 4'b1010) begin
            errors++;
            $display("FAIL oversize_status: got err/done/rst/rdy %b, required 1010",
                     {error_o, done_o, core_rst_o, byte_ready_o});
        end
        @(negedge clk);
        byte_i       = 8'h55;
        byte_valid_i = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        byte_valid_i = 1'b0;
        checks++;
        if (weCount !== 0 || error_o !== 1'b1 || byte_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL oversize_hold: got writes %0d err %b rdy %b, required 0 1 0",
                     weCount, error_o, byte_ready_o);
        end
    endtask

    task automatic test_reset_mid_word();
        applyReset();
        sendByte(8'h02, 1'b0);
        sendByte(8'h00, 1'b0);
        sendByte(8'h13, 1'b0);
        sendByte(8'h00, 1'b0);
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if (byte_ready_o !== 1'b0 || core_rst_o !== 1'b1 || WE_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_word_reset: got rdy %b rst %b we %b, required 0 1 0",
                     byte_ready_o, core_rst_o, WE_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
        weCount = 0;
        wordsQ = '{32'h0000_0013, 32'h0010_0093};
        sendLoad(2, xorOfWords(2), 0);
        @(negedge clk);
        checks++;
        if (done_o !== 1'b1 || weCount !== 2 || expQ.size() != 0) begin
            errors++;
            $display("FAIL mid_word_reload: got done %b writes %0d pending %0d, required 1 2 0",
                     done_o, weCount, expQ.size());
        end
    endtask

    task automatic test_reset_inflight();
        applyReset();
        sendByte(8'h01, 1'b0);
        sendByte(8'h00, 1'b0);
        sendByte(8'hEF, 1'b0);
        sendByte(8'hBE, 1'b0);
        sendByte(8'hAD, 1'b0);
        @(negedge clk);
        byte_i       = 8'hDE;
        byte_valid_i = 1'b1;
        @(posedge clk);
        #1;
        byte_valid_i = 1'b0;
        checks++;
        if (WE_o !== 1'b1 || AddrW_o !== '0 || DataW_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL inflight_write: got we %b addr %0h data %08h, required 1 0 deadbeef",
                     WE_o, AddrW_o, DataW_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (WE_o !== 1'b0 || DataW_o !== 32'd0) begin
            errors++;
            $display("FAIL inflight_cancel: got we %b data %08h, required 0 00000000",
                     WE_o, DataW_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
        checks++;
        if (weCount !== 0) begin
            errors++;
            $display("FAIL inflight_count: got %0d writes seen, required 0", weCount);
        end
    endtask

    task automatic test_full_depth();
        applyReset();
        wordsQ.delete();
        for (int w = 0; w < int'(MW); w++) begin
            wordsQ.push_back(32'(w));
        end
        sendLoad(int'(MW), xorOfWords(int'(MW)), 0);
        checks++;
        if ({done_o, core_rst_o, error_o} !== 3'b100) begin
            errors++;
            $display("FAIL full_status: got done/rst/err %b, required 100",
                     {done_o, core_rst_o, error_o});
        end
        @(negedge clk);
        checks++;
        if (weCount !== int'(MW) || lastAddr !== 12'hFFF || lastData !== 32'h0000_0FFF) begin
            errors++;
            $display("FAIL full_last: got writes %0d last %0h/%08h, required %0d fff/00000fff",
                     weCount, lastAddr, lastData, MW);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        weCount      = 0;
        rst_i        = 1'b1;
        byte_i       = 8'h00;
        byte_valid_i = 1'b0;
        repeat (2) @(posedge clk);

        test_reset();
        test_two_word(0);
        test_bad_csum();
        test_zero_count();
        test_oversize();
        test_two_word(2);
        test_reset_mid_word();
        test_reset_inflight();
        test_full_depth();

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
